// File: rtl/bcd_7seg_scan.sv
// Time-multiplexed 3-digit BCD driver for a common-anode 7-segment display.
// Loads are double-buffered and only take effect at a frame boundary, so a frame never tears.
module bcd_7seg_scan #(
  parameter int unsigned DIV = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] BCD,
  input  logic        LD,
  input  logic        LZB,
  output logic [6:0]  SEG,
  output logic [2:0]  AN,
  output logic        ACK
);

  localparam int unsigned PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PresLast = PW'(DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [11:0]   disp_q, disp_d;
  logic [11:0]   pend_q, pend_d;
  logic          flag_q, flag_d;
  logic [6:0]    seg_q, seg_d;
  logic [2:0]    an_q, an_d;
  logic          ack_q, ack_d;

  logic          wrap, commit, blank;
  logic [3:0]    digit;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  always_comb begin
    wrap    = (presc_q == PresLast);
    presc_d = wrap ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (wrap) idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;

    commit = wrap && (idx_q == 2'd2) && flag_q;
    disp_d = commit ? pend_q : disp_q;

    // A load coinciding with a commit becomes the next pending value.
    pend_d = pend_q;
    flag_d = flag_q;
    if (LD) begin
      pend_d = BCD;
      flag_d = 1'b1;
    end else if (commit) begin
      flag_d = 1'b0;
    end
    ack_d = commit;

    // Outputs are computed from next-state values so the registered drive lines up with the
    // counters without an extra cycle of lag.
    case (idx_d)
      2'd0:    digit = disp_d[3:0];
      2'd1:    digit = disp_d[7:4];
      default: digit = disp_d[11:8];
    endcase
    blank = LZB && (((idx_d == 2'd2) && (disp_d[11:8] == 4'd0)) ||
                    ((idx_d == 2'd1) && (disp_d[11:4] == 8'd0)));

    seg_d = 7'h7F;
    an_d  = 3'b111;
    if ((presc_d != '0) && !blank) begin
      seg_d = decode(digit);
      case (idx_d)
        2'd0:    an_d = 3'b110;
        2'd1:    an_d = 3'b101;
        default: an_d = 3'b011;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= 2'd0;
      disp_q  <= 12'h000;
      pend_q  <= 12'h000;
      flag_q  <= 1'b0;
      seg_q   <= 7'h7F;
      an_q    <= 3'b111;
      ack_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      flag_q  <= flag_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      ack_q   <= ack_d;
    end
  end

  assign SEG = seg_q;
  assign AN  = an_q;
  assign ACK = ack_q;

endmodule

// File: doc/bcd_7seg_scan.md
BCD_7SEG_SCAN -- requirements
Module: bcd_7seg_scan

Interface
REQ-001 SHALL have parameter DIV, default 1000: clock cycles per digit slot; legal range DIV >= 2.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port BCD  input  12  packed 3-digit BCD value: [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-005 SHALL have port LD  input  1  load strobe; BCD sampled on every clk edge where LD=1.
REQ-006 SHALL have port LZB  input  1  leading-zero blanking enable, sampled live (not latched).
REQ-007 SHALL have port SEG  output  7  segment drive {g,f,e,d,c,b,a}, active-low.
REQ-008 SHALL have port AN  output  3  digit enables, active-low; AN[0]=units, AN[1]=tens, AN[2]=hundreds.
REQ-009 SHALL have port ACK  output  1  one-cycle pulse: pending value committed to display.

Function
REQ-010 SHALL keep a prescaler counting 0..DIV-1, wrapping to 0; a slot index advancing 0->1->2->0 on each prescaler wrap.
REQ-011 SHALL map slot index 0/1/2 to units/tens/hundreds digit of the display register.
REQ-012 SHALL drive AN=3'b111 and SEG=7'h7F while prescaler==0 (one dead cycle per slot, ghost suppression).
REQ-013 SHALL, for prescaler 1..DIV-1, drive exactly one AN bit low (the slot digit) unless that digit is blanked (REQ-016).
REQ-014 SHALL register SEG, AN and ACK; outputs reflect current prescaler/index/display registers with no further cycle of lag.
REQ-015 SHALL decode digits (SEG hex, active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10; nibble A-F=3F (dash, segment g only).
REQ-016 SHALL, with LZB=1, blank hundreds when it is 0, and blank tens when hundreds and tens are both 0; units never blanked; blanked slot: AN=3'b111, SEG=7'h7F.
REQ-017 SHALL capture BCD into a pending register and set a pending flag on each clk with LD=1; later LD before commit overwrites pending (latest wins).
REQ-018 SHALL commit pending to display register only at frame end (prescaler==DIV-1 and index==2 with pending flag set); flag clears on commit.
REQ-019 SHALL assert ACK for exactly the one cycle after commit (first cycle of new frame, index 0, prescaler 0); one ACK per commit regardless of LD count.
REQ-020 SHALL, when LD=1 on the commit cycle, commit the prior pending value, store the new BCD as pending and keep the flag set (commits next frame).
REQ-021 SHALL never alter display register mid-frame (no tearing); with no pending data the display register holds indefinitely.

Reset
REQ-022 SHALL, while rst_n=0, force immediately: prescaler 0, index 0, display 12'h000, pending 12'h000, flag 0, AN 3'b111, SEG 7'h7F, ACK 0.
REQ-023 SHALL, after rst_n deasserts, begin at index 0 prescaler 0 on the first clk edge; a pending load in progress at reset is discarded, no ACK.

Verification (DIV=4)
REQ-024 SHALL cover: reset, LZB=0, no LD -> AN repeats 111,110,110,110,111,101,101,101,111,011,011,011; SEG=7'h40 on active cycles; ACK never high.
REQ-025 SHALL cover: LD=1 one cycle with BCD=12'h255 mid-frame -> ACK one cycle at next frame start; then units SEG 12, tens 12, hundreds 24.
REQ-026 SHALL cover: LZB=1, BCD=12'h007 loaded -> hundreds/tens slots AN=111 SEG=7F; units AN=110 SEG=78; LZB=1 with 12'h000 -> units shows 40.
REQ-027 SHALL cover: BCD=12'h0A0 loaded, LZB=0 -> tens slot SEG=3F, units and hundreds SEG=40.
REQ-028 SHALL cover: LD with 12'h123 then 12'h045 in same frame -> single ACK, display 045 (no 123 frame); LD on commit cycle -> second ACK exactly one frame (12 cycles) later.
REQ-029 SHALL cover: rst_n low at prescaler 2 of tens slot with pending set -> AN=111, SEG=7F, ACK=0 asynchronously; after release display 000, no ACK.
